// File: rtl/desloca_sl2_pkg.sv
// Shared MIPS datapath constants used by the branch-offset shifter.
package desloca_sl2_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BRANCH_SHIFT = 2;

endpackage

// File: rtl/desloca_sl2_if.sv
// Bus between the immediate source and the branch-offset shifter.
interface desloca_sl2_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] Signlmm;
    logic [WIDTH-1:0] desloca;
    logic [WIDTH-1:0] desloca_q;
    logic             out_valid;
    logic             ovf;

    modport master (
        output in_valid,
        output Signlmm,
        input  desloca,
        input  desloca_q,
        input  out_valid,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  Signlmm,
        output desloca,
        output desloca_q,
        output out_valid,
        output ovf
    );
endinterface

// File: rtl/desloca_sl2_sl_comb.sv
// Pure combinational logical left shift with signed-overflow detect.
module desloca_sl2_sl_comb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 2
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    assign dout = din << SHIFT;

    // Overflow when any bit that becomes (or is lost above) the sign differs from the sign.
    always_comb begin
        ovf = 1'b0;
        for (int i = WIDTH - 1 - SHIFT; i < WIDTH - 1; i++) begin
            if (din[i] != din[WIDTH-1]) begin
                ovf = 1'b1;
            end
        end
    end

endmodule

// File: rtl/desloca_sl2.sv
// Branch-offset shifter: combinational result plus a registered copy with valid/overflow.
module desloca_sl2
    import desloca_sl2_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned SHIFT = BRANCH_SHIFT
) (
    input logic          clk,
    input logic          rst_n,
    desloca_sl2_if.slave bus
);

    logic [WIDTH-1:0] shifted;
    logic             ovf_c;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;
    logic             valid_q;

    desloca_sl2_sl_comb #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_sl_comb (
        .din  (bus.Signlmm),
        .dout (shifted),
        .ovf  (ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            // Data and overflow hold across idle cycles.
            if (bus.in_valid) begin
                data_q <= shifted;
                ovf_q  <= ovf_c;
            end
        end
    end

    assign bus.desloca   = shifted;
    assign bus.desloca_q = data_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_desloca_sl2.sv
// Self-checking bench for desloca_sl2 against an arithmetic reference model.
module tb_desloca_sl2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    logic [31:0] exp_q;
    logic        exp_ovf;
    logic        exp_valid;

    desloca_sl2_if #(.WIDTH(32)) bus ();

    desloca_sl2 #(
        .WIDTH (32),
        .SHIFT (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word offset to byte offset is a multiply by four, truncated to 32 bits.
    function automatic logic [31:0] mdl_shift(input logic [31:0] x);
        return x * 32'd4;
    endfunction

    // Overflow when the truncated result, read as signed, differs from the true product.
    function automatic logic mdl_ovf(input logic [31:0] x);
        longint      prod;
        logic [31:0] r;
        prod = longint'($signed(x)) * 64'sd4;
        r    = x * 32'd4;
        return prod != longint'($signed(r));
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.Signlmm  = 32'h0000_0001;
        #3;
        vectors++;
        if (bus.desloca_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_q got %h exp %h", bus.desloca_q, 32'h0);
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got v=%b o=%b exp v=0 o=0", bus.out_valid, bus.ovf);
        end
        vectors++;
        if (bus.desloca !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL reset_comb got %h exp %h", bus.desloca, 32'h4);
        end
        @(posedge clk) #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.desloca_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_held got v=%b q=%h exp v=0 q=0", bus.out_valid, bus.desloca_q);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        exp_q        = 32'h0;
        exp_ovf      = 1'b0;
        exp_valid    = 1'b0;
    endtask

    task automatic test_comb();
        logic [31:0] pats [5];
        pats = '{32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8765_4321};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.Signlmm  = pats[i];
            #10;
            vectors++;
            if (bus.desloca !== mdl_shift(pats[i])) begin
                miscompares++;
                $display("FAIL comb_%0d got %h exp %h", i, bus.desloca, mdl_shift(pats[i]));
            end
        end
        exp_valid = 1'b0;
    endtask

    task automatic test_registered();
        logic [31:0] pats [5];
        logic [31:0] eq  [5];
        logic        eo  [5];
        pats = '{32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8765_4321};
        eq   = '{32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'h48D1_59E0, 32'h1D95_0C84};
        eo   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.Signlmm  = pats[i];
            @(posedge clk) #1;
            vectors++;
            if (bus.desloca_q !== eq[i] || bus.out_valid !== 1'b1 || bus.ovf !== eo[i]) begin
                miscompares++;
                $display("FAIL reg_%0d got q=%h v=%b o=%b exp q=%h v=1 o=%b",
                         i, bus.desloca_q, bus.out_valid, bus.ovf, eq[i], eo[i]);
            end
        end
        exp_q     = eq[4];
        exp_ovf   = eo[4];
        exp_valid = 1'b1;
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Signlmm  = 32'h0000_0001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.Signlmm  = 32'h1234_5678;
        @(posedge clk) #1;
        vectors++;
        if (bus.desloca_q !== 32'h4 || bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL hold got q=%h v=%b o=%b exp q=00000004 v=0 o=0",
                     bus.desloca_q, bus.out_valid, bus.ovf);
        end
        vectors++;
        if (bus.desloca !== 32'h48D1_59E0) begin
            miscompares++;
            $display("FAIL hold_comb got %h exp %h", bus.desloca, 32'h48D1_59E0);
        end
        exp_q     = 32'h4;
        exp_ovf   = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Signlmm  = 32'h8765_4321;
        @(posedge clk) #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.desloca_q !== 32'h0 || bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst got q=%h v=%b o=%b exp q=0 v=0 o=0",
                     bus.desloca_q, bus.out_valid, bus.ovf);
        end
        bus.Signlmm = 32'h1234_5678;
        #1;
        vectors++;
        if (bus.desloca !== mdl_shift(32'h1234_5678)) begin
            miscompares++;
            $display("FAIL async_comb got %h exp %h", bus.desloca, mdl_shift(32'h1234_5678));
        end
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        bus.Signlmm  = 32'h4000_0000;
        @(posedge clk) #1;
        vectors++;
        if (bus.desloca_q !== 32'h0 || bus.out_valid !== 1'b1 || bus.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst got q=%h v=%b o=%b exp q=0 v=1 o=1",
                     bus.desloca_q, bus.out_valid, bus.ovf);
        end
        exp_q     = 32'h0;
        exp_ovf   = 1'b1;
        exp_valid = 1'b1;
    endtask

    task automatic test_random(input int n);
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = $urandom;
            if ((i % 4) == 0) d[31:29] = 3'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            bus.Signlmm  = d;
            bus.in_valid = v;
            #1;
            vectors++;
            if (bus.desloca !== mdl_shift(d)) begin
                miscompares++;
                $display("FAIL rand_comb_%0d got %h exp %h", i, bus.desloca, mdl_shift(d));
            end
            @(posedge clk) #1;
            exp_valid = v;
            if (v) begin
                exp_q   = mdl_shift(d);
                exp_ovf = mdl_ovf(d);
            end
            vectors++;
            if (bus.desloca_q !== exp_q || bus.out_valid !== exp_valid || bus.ovf !== exp_ovf) begin
                miscompares++;
                $display("FAIL rand_reg_%0d got q=%h v=%b o=%b exp q=%h v=%b o=%b", i,
                         bus.desloca_q, bus.out_valid, bus.ovf, exp_q, exp_valid, exp_ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = $urandom;
            bus.in_valid = 1'b1;
            bus.Signlmm  = d;
            @(posedge clk) #1;
            vectors++;
            if (bus.desloca_q !== mdl_shift(d) || bus.out_valid !== 1'b1 ||
                bus.ovf !== mdl_ovf(d)) begin
                miscompares++;
                $display("FAIL b2b_%0d got q=%h v=%b o=%b exp q=%h v=1 o=%b", i,
                         bus.desloca_q, bus.out_valid, bus.ovf, mdl_shift(d), mdl_ovf(d));
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_comb();
        test_registered();
        test_hold();
        test_async_reset();
        test_random(300);
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
